// File: rtl/jtag_scan_master.sv
// rtl/jtag_scan_master.sv - JTAG initiator: TAP reset on init, then one IR/DR scan per command
// Bits are shifted LSB first; captured TDO bits return on the response channel.
module jtag_scan_master #(
  parameter int MAX_LEN = 38,
  parameter int TCK_DIV = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_is_ir,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_error,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic               busy
);

  localparam int            DW        = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(TCK_DIV - 1);
  localparam logic [6:0]    INIT_LAST = 7'd5;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_SCAN, S_RSP} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DW-1:0]        r_div;
  logic                 r_tck;
  logic                 r_tms;
  logic                 r_tdi;
  logic [5:0]           r_cyc;
  logic [5:0]           r_bit;
  logic                 r_is_ir;
  logic [5:0]           r_len;
  logic [MAX_LEN-1:0]   r_sh;
  logic [MAX_LEN-1:0]   r_rsp;
  logic                 r_err;

  logic                 w_active;
  logic                 w_tick;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_cmd_bad;
  logic [6:0]           w_head;
  logic [6:0]           w_shift_end;
  logic [6:0]           w_last;
  logic [6:0]           w_cyc;
  logic [6:0]           w_cyc_nxt;
  logic                 w_in_shift;
  logic                 w_nxt_shift;
  logic                 w_tms_nxt;

  assign w_active    = (r_state == S_INIT) || (r_state == S_SCAN);
  assign w_tick      = w_active && (r_div == DIV_LAST);
  assign w_rise      = w_tick && !r_tck;
  assign w_fall      = w_tick && r_tck;
  assign w_cmd_bad   = (cmd_len == 6'd0) || (7'(cmd_len) > 7'(MAX_LEN));

  // Scan cycle map: head (IR 1,1,0,0 / DR 1,0,0), N shift cycles, then Update and Idle.
  assign w_head      = r_is_ir ? 7'd4 : 7'd3;
  assign w_shift_end = w_head + 7'(r_len);
  assign w_last      = w_shift_end + 7'd1;
  assign w_cyc       = 7'(r_cyc);
  assign w_cyc_nxt   = w_cyc + 7'd1;
  assign w_in_shift  = (w_cyc >= w_head) && (w_cyc < w_shift_end);
  assign w_nxt_shift = (w_cyc_nxt >= w_head) && (w_cyc_nxt < w_shift_end);

  always_comb begin
    w_tms_nxt = 1'b0;
    if (r_state == S_INIT) begin
      w_tms_nxt = (w_cyc_nxt < INIT_LAST);
    end else if (w_cyc_nxt < w_head) begin
      w_tms_nxt = r_is_ir && (w_cyc_nxt < 7'd2);
    end else if (w_cyc_nxt < w_shift_end) begin
      w_tms_nxt = (w_cyc_nxt == w_shift_end - 7'd1);
    end else begin
      w_tms_nxt = (w_cyc_nxt == w_shift_end);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  if (w_fall && (w_cyc == INIT_LAST)) w_state_nxt = S_IDLE;
      S_IDLE:  if (cmd_valid) w_state_nxt = w_cmd_bad ? S_RSP : S_SCAN;
      S_SCAN:  if (w_fall && (w_cyc == w_last)) w_state_nxt = S_RSP;
      S_RSP:   if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div   <= '0;
      r_tck   <= 1'b0;
      r_tms   <= 1'b1;
      r_tdi   <= 1'b0;
      r_cyc   <= '0;
      r_bit   <= '0;
      r_is_ir <= 1'b0;
      r_len   <= '0;
      r_sh    <= '0;
      r_rsp   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tck <= 1'b0;
          r_tms <= 1'b0;
          r_tdi <= 1'b0;
          r_div <= '0;
          r_cyc <= '0;
          r_bit <= '0;
          if (cmd_valid) begin
            r_is_ir <= cmd_is_ir;
            r_len   <= cmd_len;
            r_sh    <= cmd_data;
            r_rsp   <= '0;
            r_err   <= w_cmd_bad;
            r_tms   <= !w_cmd_bad;
          end
        end
        S_INIT, S_SCAN: begin
          r_div <= w_tick ? '0 : r_div + DW'(1);
          if (w_tick) r_tck <= !r_tck;
          // TDO is captured on the same clk edge that raises TCK, before the target reacts.
          if (w_rise && (r_state == S_SCAN) && w_in_shift) begin
            r_rsp[r_bit] <= tdo;
            r_bit        <= r_bit + 6'd1;
          end
          if (w_fall) begin
            r_cyc <= r_cyc + 6'd1;
            r_tms <= w_tms_nxt;
            if ((r_state == S_SCAN) && w_nxt_shift) begin
              r_tdi <= r_sh[0];
              r_sh  <= r_sh >> 1;
            end else begin
              r_tdi <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign tck       = r_tck;
  assign tms       = r_tms;
  assign tdi       = r_tdi;
  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = (r_state == S_RSP);
  assign rsp_data  = r_rsp;
  assign rsp_error = r_err;

endmodule

// File: tb/tb_jtag_scan_master.sv
// tb/tb_jtag_scan_master.sv - scoreboard bench for jtag_scan_master with a TAP model on the far side
module tb_jtag_scan_master;

  localparam int MAX_LEN = 38;
  localparam int TCK_DIV = 2;

  localparam logic [3:0] TLR = 4'd0,  RTI = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3;
  localparam logic [3:0] SH_DR = 4'd4, EX1_DR = 4'd5, PAU_DR = 4'd6, EX2_DR = 4'd7;
  localparam logic [3:0] UPD_DR = 4'd8, SEL_IR = 4'd9, CAP_IR = 4'd10, SH_IR = 4'd11;
  localparam logic [3:0] EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic               cmd_is_ir = 1'b0;
  logic [5:0]         cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [MAX_LEN-1:0] rsp_data;
  logic               rsp_error;
  logic               tck;
  logic               tms;
  logic               tdi;
  logic               tdo;
  logic               busy;

  jtag_scan_master #(.MAX_LEN(MAX_LEN), .TCK_DIV(TCK_DIV)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_ir(cmd_is_ir),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Target side: IEEE 1149.1 TAP with a 2-bit IR capturing 2'b01; DR path is a 1-bit delay loopback.
  logic [3:0] tap_st = SH_DR;
  logic [1:0] ir_sr = 2'b00;
  logic [1:0] ir = 2'b00;
  logic       dly = 1'b0;
  logic       tdo_one = 1'b0;
  logic       tms_hist [0:4095];
  logic       tdi_hist [0:4095];
  int         n_rise = 0;
  int         n_shift = 0;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
    case (s)
      TLR:     return m ? TLR    : RTI;
      RTI:     return m ? SEL_DR : RTI;
      SEL_DR:  return m ? SEL_IR : CAP_DR;
      CAP_DR:  return m ? EX1_DR : SH_DR;
      SH_DR:   return m ? EX1_DR : SH_DR;
      EX1_DR:  return m ? UPD_DR : PAU_DR;
      PAU_DR:  return m ? EX2_DR : PAU_DR;
      EX2_DR:  return m ? UPD_DR : SH_DR;
      UPD_DR:  return m ? SEL_DR : RTI;
      SEL_IR:  return m ? TLR    : CAP_IR;
      CAP_IR:  return m ? EX1_IR : SH_IR;
      SH_IR:   return m ? EX1_IR : SH_IR;
      EX1_IR:  return m ? UPD_IR : PAU_IR;
      PAU_IR:  return m ? EX2_IR : PAU_IR;
      EX2_IR:  return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  assign tdo = tdo_one ? 1'b1 : ((tap_st == SH_IR) ? ir_sr[0] : dly);

  always @(posedge tck) begin
    if (n_rise < 4096) tms_hist[n_rise] = tms;
    n_rise++;
    if (tap_st == SH_DR || tap_st == SH_IR) begin
      if (n_shift < 4096) tdi_hist[n_shift] = tdi;
      n_shift++;
    end
    case (tap_st)
      CAP_IR:  ir_sr <= 2'b01;
      SH_IR:   ir_sr <= {tdi, ir_sr[1]};
      UPD_IR:  ir    <= ir_sr;
      default: ;
    endcase
    dly    <= tdi;
    tap_st <= tap_next(tap_st, tms);
  end

  typedef struct packed {
    logic               err;
    logic [MAX_LEN-1:0] data;
  } exp_t;
  exp_t sb [$];

  function automatic logic [63:0] exp_tms(input logic ir_scan, input int n);
    logic [63:0] v;
    int p;
    v = '0;
    v[0] = 1'b1;
    p = 1;
    if (ir_scan) begin
      v[1] = 1'b1;
      p = 2;
    end
    p = p + 2 + n - 1;
    v[p] = 1'b1;
    v[p+1] = 1'b1;
    return v;
  endfunction

  function automatic logic [MAX_LEN-1:0] len_mask(input int n);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < n && i < MAX_LEN; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [MAX_LEN-1:0] loopback(input logic [MAX_LEN-1:0] d, input int n);
    return (d << 1) & len_mask(n);
  endfunction

  task automatic do_init();
    int cnt;
    int base_r;
    logic [63:0] obs;
    chk("reset_ctl", 64'({tck, tms, tdi, cmd_ready, rsp_valid, rsp_error, busy}), 64'(7'b0100001));
    chk("reset_data", 64'(rsp_data), 64'd0);
    base_r = n_rise;
    reset = 1'b0;
    cnt = 1;
    while (!cmd_ready && cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("init_ready_clk", 64'(cnt), 64'(12 * TCK_DIV + 1));
    chk("init_busy", 64'(busy), 64'd0);
    chk("init_rises", 64'(n_rise - base_r), 64'd6);
    obs = '0;
    for (int i = 0; i < 6; i++) obs[i] = tms_hist[base_r + i];
    chk("init_tms", obs, 64'h1F);
    chk("init_tap", 64'(tap_st), 64'(RTI));
    chk("init_pins", 64'({tck, tms}), 64'd0);
    @(negedge clk);
  endtask

  task automatic run_scan(input logic ir_scan, input int len, input logic [MAX_LEN-1:0] data,
                          input logic [MAX_LEN-1:0] exp_d, input logic exp_err, input int hold);
    int t;
    int base_r;
    int base_s;
    int rises;
    logic bad;
    logic [63:0] obs;
    logic [MAX_LEN+2:0] snap;
    exp_t e;
    t = 0;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    base_r = n_rise;
    base_s = n_shift;
    cmd_valid = 1'b1;
    cmd_is_ir = ir_scan;
    cmd_len   = 6'(len);
    cmd_data  = data;
    sb.push_back({exp_err, exp_d});
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cmd_ready_drop", 64'({cmd_ready, busy}), 64'd1);
    t = 0;
    while (!rsp_valid && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("rsp_valid_wait", 64'(rsp_valid), 64'd1);
    e = sb.pop_front();
    chk("rsp_data", 64'(rsp_data), 64'(e.data));
    chk("rsp_error", 64'(rsp_error), 64'(e.err));
    rises = exp_err ? 0 : len + (ir_scan ? 6 : 5);
    chk("tck_rises", 64'(n_rise - base_r), 64'(rises));
    if (!exp_err) begin
      obs = '0;
      for (int i = 0; i < rises; i++) obs[i] = tms_hist[base_r + i];
      chk("tms_seq", obs, exp_tms(ir_scan, len));
      obs = '0;
      for (int i = 0; i < len; i++) obs[i] = tdi_hist[base_s + i];
      chk("tdi_seq", obs, 64'(data & len_mask(len)));
      chk("tap_idle", 64'(tap_st), 64'(RTI));
    end
    chk("end_pins", 64'({tck, tms}), 64'd0);
    if (hold > 0) begin
      snap = {rsp_valid, cmd_ready, rsp_error, rsp_data};
      bad = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if ({rsp_valid, cmd_ready, rsp_error, rsp_data} !== snap || snap[MAX_LEN+2:MAX_LEN+1] !== 2'b10)
          bad = 1'b1;
      end
      chk("rsp_hold", 64'(bad), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done", 64'({rsp_valid, cmd_ready, busy}), 64'(3'b010));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rnd;
    logic [MAX_LEN-1:0] d;
    int len;
    int t;
    int base_s;
    repeat (3) @(posedge clk);
    @(negedge clk);
    do_init();

    run_scan(1'b0, 8, 38'hA5, 38'h4A, 1'b0, 0);
    run_scan(1'b1, 2, 38'h2, 38'h1, 1'b0, 0);
    chk("ir_in", 64'(ir), 64'(2'b10));
    tdo_one = 1'b1;
    run_scan(1'b0, 38, 38'h2A_AAAA_AAAA, 38'h3F_FFFF_FFFF, 1'b0, 0);
    tdo_one = 1'b0;
    run_scan(1'b0, 0, 38'h15, 38'h0, 1'b1, 20);
    run_scan(1'b0, 39, 38'h3, 38'h0, 1'b1, 0);
    run_scan(1'b0, 1, 38'h1, loopback(38'h1, 1), 1'b0, 0);
    for (int r = 0; r < 3; r++) begin
      rnd = {$urandom, $urandom};
      d   = rnd[MAX_LEN-1:0];
      len = $urandom_range(1, MAX_LEN);
      run_scan(1'b0, len, d, loopback(d, len), 1'b0, 0);
    end

    t = 0;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    base_s = n_shift;
    cmd_valid = 1'b1;
    cmd_is_ir = 1'b0;
    cmd_len   = 6'd16;
    cmd_data  = 38'hFFFF;
    sb.push_back({1'b0, loopback(38'hFFFF, 16)});
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while (n_shift - base_s < 4 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("shift4_wait", 64'(n_shift - base_s), 64'd4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midscan_reset", 64'({tck, tms, rsp_valid, cmd_ready, busy}), 64'(5'b01001));
    sb.delete();
    @(negedge clk);
    do_init();
    run_scan(1'b0, 16, 38'hC3A5, loopback(38'hC3A5, 16), 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
